// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the CPU and NREQ peripherals,
// with starvation-bounded CPU priority, round-robin peripherals and an I/O write guard.
module dmem_arbiter #(
   parameter int NREQ = 2,
   parameter int STARVE_LIMIT = 7,
   parameter int WR_TOP = 1011
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [9:0]        cpu_addr,
   input  logic [23:0]       cpu_wdata,
   output logic              cpu_stall,
   output logic [23:0]       cpu_rdata,
   input  logic [NREQ-1:0]   p_req,
   input  logic [NREQ-1:0]   p_we,
   input  logic [NREQ*10-1:0] p_addr,
   input  logic [NREQ*24-1:0] p_wdata,
   output logic [NREQ-1:0]   p_ack,
   output logic [23:0]       p_rdata,
   output logic [9:0]        mem_addr,
   output logic              mem_we,
   output logic [23:0]       mem_wdata,
   input  logic [23:0]       mem_rdata,
   output logic              wr_err
);
   localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(STARVE_LIMIT + 1) > 3 ? $clog2(STARVE_LIMIT + 1) : 3;

   logic [PW-1:0] rrPtr, starveSel, rrSel, sel, idx;
   logic [CW-1:0] starveCnt [NREQ];
   logic [9:0]    pAddr [NREQ];
   logic [23:0]   pData [NREQ];
   logic          starveHit, rrHit, pGnt, cpuGnt, gWe;

   for (genvar i = 0; i < NREQ; i++) begin : gUnpack
      assign pAddr[i] = p_addr[i*10 +: 10];
      assign pData[i] = p_wdata[i*24 +: 24];
   end

   // scan from rrPtr backwards so the first candidate at/after rrPtr wins
   always_comb begin
      starveHit = 1'b0;
      rrHit = 1'b0;
      starveSel = '0;
      rrSel = '0;
      idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = PW'((int'(rrPtr) + k) % NREQ);
         if (p_req[idx] && starveCnt[idx] == CW'(STARVE_LIMIT)) begin
            starveHit = 1'b1;
            starveSel = idx;
         end
         if (p_req[idx]) begin
            rrHit = 1'b1;
            rrSel = idx;
         end
      end
   end

   assign sel       = starveHit ? starveSel : rrSel;
   assign pGnt      = rst_n && (starveHit || (!cpu_req && rrHit));
   assign cpuGnt    = rst_n && cpu_req && !starveHit;
   assign mem_addr  = cpuGnt ? cpu_addr : pGnt ? pAddr[sel] : '0;
   assign mem_wdata = cpuGnt ? cpu_wdata : pGnt ? pData[sel] : '0;
   assign gWe       = cpuGnt ? cpu_we : pGnt && p_we[sel];
   assign mem_we    = gWe && mem_addr <= 10'(WR_TOP);
   assign wr_err    = gWe && mem_addr > 10'(WR_TOP);
   assign p_ack     = pGnt ? NREQ'(1) << sel : '0;
   assign cpu_stall = cpu_req && !cpuGnt;
   assign cpu_rdata = mem_rdata;
   assign p_rdata   = mem_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rrPtr <= '0;
         for (int i = 0; i < NREQ; i++) starveCnt[i] <= '0;
      end else begin
         if (pGnt) rrPtr <= PW'((int'(sel) + 1) % NREQ);
         for (int i = 0; i < NREQ; i++)
            starveCnt[i] <= ((pGnt && sel == PW'(i)) || !p_req[i]) ? '0 :
                            starveCnt[i] + ((starveCnt[i] != CW'(STARVE_LIMIT)) ? CW'(1) : CW'(0));
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios for dmem_arbiter with a byte-wide
// little-endian memory model written on the falling edge.
module tb_dmem_arbiter;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [9:0]  cpu_addr = '0;
   logic [23:0] cpu_wdata = '0;
   logic        cpu_stall;
   logic [23:0] cpu_rdata, p_rdata, mem_wdata, mem_rdata;
   logic [1:0]  p_req = '0, p_we = '0, p_ack;
   logic [9:0]  pa0 = '0, pa1 = '0, mem_addr;
   logic [23:0] pd0 = '0, pd1 = '0;
   logic        mem_we, wr_err;
   logic [7:0]  mem [1024];
   int tests = 0, fails = 0;

   dmem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
      .p_req(p_req), .p_we(p_we), .p_addr({pa1, pa0}), .p_wdata({pd1, pd0}),
      .p_ack(p_ack), .p_rdata(p_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .wr_err(wr_err)
   );

   always #5 clk = ~clk;

   assign mem_rdata = {mem[mem_addr + 10'd2], mem[mem_addr + 10'd1], mem[mem_addr]};

   always @(negedge clk)
      if (mem_we) begin
         mem[mem_addr] = mem_wdata[7:0];
         mem[mem_addr + 10'd1] = mem_wdata[15:8];
         mem[mem_addr + 10'd2] = mem_wdata[23:16];
      end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cpu_req = 1'b1;
      #1;
      tests += 4;
      if (cpu_stall !== 1'b1) begin fails++; $display("FAIL reset_stall got %b want 1", cpu_stall); end
      if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", mem_we); end
      if (p_ack !== 2'b00) begin fails++; $display("FAIL reset_ack got %b want 00", p_ack); end
      if (wr_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", wr_err); end
      cpu_req = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_cpu_write();
      step();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd100; cpu_wdata = 24'hABCDEF;
      #1;
      tests += 4;
      if (mem_we !== 1'b1) begin fails++; $display("FAIL cpuwr_we got %b want 1", mem_we); end
      if (cpu_stall !== 1'b0) begin fails++; $display("FAIL cpuwr_stall got %b want 0", cpu_stall); end
      if (mem_addr !== 10'd100) begin fails++; $display("FAIL cpuwr_addr got %0d want 100", mem_addr); end
      if (mem_wdata !== 24'hABCDEF) begin fails++; $display("FAIL cpuwr_data got %h want abcdef", mem_wdata); end
      @(negedge clk);
      #1;
      tests++;
      if ({mem[102], mem[101], mem[100]} !== 24'hABCDEF) begin
         fails++; $display("FAIL cpuwr_bytes got %h %h %h want ab cd ef", mem[102], mem[101], mem[100]);
      end
      step();
      cpu_we = 1'b0;
      #1;
      tests++;
      if (cpu_rdata !== 24'hABCDEF) begin fails++; $display("FAIL cpurd_data got %h want abcdef", cpu_rdata); end
      step();
      cpu_req = 1'b0;
   endtask

   task automatic test_starve();
      for (int c = 1; c <= 10; c++) begin
         step();
         if (c == 1) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd5;
            p_req = 2'b01; p_we = 2'b00; pa0 = 10'd200;
         end
         #1;
         tests += 2;
         if (p_ack !== (c == 8 ? 2'b01 : 2'b00)) begin
            fails++; $display("FAIL starve_ack c=%0d got %b want %b", c, p_ack, (c == 8 ? 2'b01 : 2'b00));
         end
         if (cpu_stall !== (c == 8)) begin
            fails++; $display("FAIL starve_stall c=%0d got %b want %b", c, cpu_stall, (c == 8));
         end
         if (c == 8) begin
            tests++;
            if (mem_addr !== 10'd200) begin fails++; $display("FAIL starve_addr got %0d want 200", mem_addr); end
         end
      end
      step();
      cpu_req = 1'b0; p_req = 2'b00;
   endtask

   task automatic test_round_robin();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         if (c == 0) begin
            cpu_req = 1'b0; p_req = 2'b11; p_we = 2'b00; pa0 = 10'd300; pa1 = 10'd400;
         end
         #1;
         tests += 2;
         if (p_ack !== (c % 2 == 1 ? 2'b10 : 2'b01)) begin
            fails++; $display("FAIL rr_ack c=%0d got %b want %b", c, p_ack, (c % 2 == 1 ? 2'b10 : 2'b01));
         end
         if (mem_addr !== (c % 2 == 1 ? 10'd400 : 10'd300)) begin
            fails++; $display("FAIL rr_addr c=%0d got %0d want %0d", c, mem_addr, (c % 2 == 1 ? 400 : 300));
         end
      end
      step();
      p_req = 2'b00;
   endtask

   task automatic test_guard();
      mem[1011] = 8'h00; mem[1012] = 8'h11; mem[1013] = 8'h22; mem[1014] = 8'h33;
      step();
      p_req = 2'b10; p_we = 2'b10; pa1 = 10'd1012; pd1 = 24'h123456;
      #1;
      tests += 3;
      if (p_ack !== 2'b10) begin fails++; $display("FAIL guard_ack got %b want 10", p_ack); end
      if (wr_err !== 1'b1) begin fails++; $display("FAIL guard_err got %b want 1", wr_err); end
      if (mem_we !== 1'b0) begin fails++; $display("FAIL guard_we got %b want 0", mem_we); end
      @(negedge clk);
      #1;
      tests++;
      if ({mem[1014], mem[1013], mem[1012]} !== 24'h332211) begin
         fails++; $display("FAIL guard_bytes got %h%h%h want 332211", mem[1014], mem[1013], mem[1012]);
      end
      step();
      pa1 = 10'd1011; pd1 = 24'h654321;
      #1;
      tests += 3;
      if (p_ack !== 2'b10) begin fails++; $display("FAIL edge_ack got %b want 10", p_ack); end
      if (wr_err !== 1'b0) begin fails++; $display("FAIL edge_err got %b want 0", wr_err); end
      if (mem_we !== 1'b1) begin fails++; $display("FAIL edge_we got %b want 1", mem_we); end
      @(negedge clk);
      #1;
      tests++;
      if ({mem[1013], mem[1012], mem[1011]} !== 24'h654321) begin
         fails++; $display("FAIL edge_bytes got %h%h%h want 654321", mem[1013], mem[1012], mem[1011]);
      end
      step();
      p_req = 2'b00; p_we = 2'b00;
   endtask

   task automatic test_read_routing();
      mem[1021] = 8'h0D; mem[1022] = 8'hF0; mem[1023] = 8'h00;
      step();
      p_req = 2'b01; p_we = 2'b00; pa0 = 10'd1021;
      #1;
      tests += 3;
      if (p_ack !== 2'b01) begin fails++; $display("FAIL rd_ack got %b want 01", p_ack); end
      if (p_rdata !== 24'h00F00D) begin fails++; $display("FAIL rd_data got %h want 00f00d", p_rdata); end
      if (wr_err !== 1'b0 || mem_we !== 1'b0) begin
         fails++; $display("FAIL rd_noerr got err=%b we=%b want 0 0", wr_err, mem_we);
      end
      step();
      p_req = 2'b00;
   endtask

   task automatic test_reset_mid();
      mem[50] = 8'h5A;
      for (int c = 1; c <= 6; c++) begin
         step();
         if (c == 1) begin
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd50; cpu_wdata = 24'h0000A5;
            p_req = 2'b01; p_we = 2'b00; pa0 = 10'd60;
            mem[50] = 8'h5A;
         end
         if (c == 6) mem[50] = 8'h5A;
      end
      #1;
      tests++;
      if (mem_we !== 1'b1) begin fails++; $display("FAIL mid_pre_we got %b want 1", mem_we); end
      rst_n = 1'b0;
      #1;
      tests += 3;
      if (mem_we !== 1'b0) begin fails++; $display("FAIL mid_we got %b want 0", mem_we); end
      if (cpu_stall !== 1'b1) begin fails++; $display("FAIL mid_stall got %b want 1", cpu_stall); end
      if (p_ack !== 2'b00) begin fails++; $display("FAIL mid_ack got %b want 00", p_ack); end
      @(negedge clk);
      #1;
      tests++;
      if (mem[50] !== 8'h5A) begin fails++; $display("FAIL mid_nowrite got %h want 5a", mem[50]); end
      step();
      rst_n = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) step();
         #1;
         tests += 2;
         if (p_ack !== (c == 8 ? 2'b01 : 2'b00)) begin
            fails++; $display("FAIL post_ack c=%0d got %b want %b", c, p_ack, (c == 8 ? 2'b01 : 2'b00));
         end
         if (cpu_stall !== (c == 8)) begin
            fails++; $display("FAIL post_stall c=%0d got %b want %b", c, cpu_stall, (c == 8));
         end
      end
      step();
      cpu_req = 1'b0; p_req = 2'b00;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      test_reset();
      test_cpu_write();
      test_starve();
      test_round_robin();
      test_guard();
      test_read_routing();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
